alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl_pkg.sv | 56 +++++
 rtl/alu_op_decode.sv | 32 +++
 rtl/alu_issue_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared opcodes, state and class types for the ALU issue controller
//
// Purpose: opcode constants, FSM state enum, instruction classification
// typedef and instruction field helpers used by alu_issue_ctrl and
// alu_op_decode.
// Ports: none (package).
package alu_issue_ctrl_pkg;

  // Opcodes 0 and 15 are unassigned and decode as illegal.
  localparam logic [3:0] OP_ILL_LO = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_OR     = 4'd4;
  localparam logic [3:0] OP_SLT    = 4'd5;
  localparam logic [3:0] OP_BEQ    = 4'd6;
  localparam logic [3:0] OP_BNE    = 4'd7;
  localparam logic [3:0] OP_BLT    = 4'd8;
  localparam logic [3:0] OP_SLL    = 4'd9;
  localparam logic [3:0] OP_SRL    = 4'd10;
  localparam logic [3:0] OP_SRA    = 4'd11;
  localparam logic [3:0] OP_NOR    = 4'd12;
  localparam logic [3:0] OP_ADDI   = 4'd13;
  localparam logic [3:0] OP_XOR    = 4'd14;
  localparam logic [3:0] OP_ILL_HI = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WRITEBACK = 2'd0,
    BRANCH    = 2'd1,
    ILLEGAL   = 2'd2
  } op_class_e;

  function automatic logic [3:0] f_opcode(input logic [15:0] i);
    return i[15:12];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] i);
    return i[11:8];
  endfunction

  function automatic logic [3:0] f_rs(input logic [15:0] i);
    return i[7:4];
  endfunction

  function automatic logic [3:0] f_rt(input logic [15:0] i);
    return i[3:0];
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational opcode classifier
//
// Purpose: map a 4-bit opcode to its instruction class and flag whether
// the second ALU operand comes from the immediate field.
// Ports:
//   opcode   in  4   instruction opcode
//   op_class out     WRITEBACK / BRANCH / ILLEGAL
//   imm_sel  out 1   1 = operand b is the zero-extended immediate
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class,
  output logic       imm_sel
);

  always_comb begin
    op_class = ILLEGAL;
    imm_sel  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
      OP_SLL, OP_SRL, OP_SRA, OP_NOR, OP_XOR: op_class = WRITEBACK;
      OP_ADDI: begin
        op_class = WRITEBACK;
        imm_sel  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT: op_class = BRANCH;
      default: op_class = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU instruction controller
//
// Purpose: accept one instruction at a time, read its operands from the
// register file, issue them to an external registered ALU, then write back
// the result or resolve a branch.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_valid/instr_ready  instruction handshake, instr is the 16-bit word
//   rf_raddr_a/b, rf_rdata_a/b  register-file read port (combinational data)
//   rf_we, rf_waddr, rf_wdata   register-file write port (WB only)
//   alu_a, alu_b, alu_ctl       registered ALU operands and opcode
//   alu_out, alu_zero           registered ALU result and zero flag
//   done, br_valid, br_taken, illegal  one-cycle WB pulses
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              done,
  output logic              br_valid,
  output logic              br_taken,
  output logic              illegal
);

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_ctl_q, alu_ctl_d;

  op_class_e op_class;
  logic      imm_sel;

  // Classification always works off the latched word, so it is stable
  // from DECODE through WB regardless of what instr does meanwhile.
  alu_op_decode u_decode (
    .opcode   (f_opcode(instr_q)),
    .op_class (op_class),
    .imm_sel  (imm_sel)
  );

  assign rf_raddr_a = REG_AW'(f_rs(instr_q));
  assign rf_raddr_b = REG_AW'(f_rt(instr_q));
  assign rf_waddr   = REG_AW'(f_rd(instr_q));
  assign rf_wdata   = alu_out;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctl    = alu_ctl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_ctl_q <= alu_ctl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctl_d   = alu_ctl_q;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    done        = 1'b0;
    br_valid    = 1'b0;
    br_taken    = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end

      DECODE: begin
        // Illegal opcodes skip the ALU entirely, leaving the operand
        // registers holding the previous issue.
        if (op_class == ILLEGAL) begin
          state_d = WB;
        end else begin
          state_d   = EXEC;
          alu_ctl_d = f_opcode(instr_q);
          alu_a_d   = rf_rdata_a;
          alu_b_d   = imm_sel ? DATA_W'(f_rt(instr_q)) : rf_rdata_b;
        end
      end

      // The ALU captures its result on the edge leaving EXEC.
      EXEC: state_d = WB;

      WB: begin
        state_d = IDLE;
        done    = 1'b1;
        case (op_class)
          WRITEBACK: rf_we = (f_rd(instr_q) != 4'd0);
          BRANCH: begin
            br_valid = 1'b1;
            br_taken = alu_zero;
          end
          ILLEGAL: illegal = 1'b1;
          default: illegal = 1'b1;
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
